// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 codes, FSM encoding and
// request classification helpers.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic is_valid_f3(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Byte loads can never be misaligned; halfwords need an even offset.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        case (funct3)
            F3_LH, F3_LHU: return offset[0];
            F3_LW:         return offset != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a loaded word.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sx;
    logic signed [31:0] half_sx;

    always_comb begin
        case (offset)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            default: byte_s = mem_rdata[31:24];
        endcase
        half_s  = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // Signed-to-wider-signed assignment replicates the sign bit.
        byte_sx = byte_s;
        half_sx = half_s;

        case (funct3)
            F3_LB:   load_data = byte_sx;
            F3_LH:   load_data = half_sx;
            F3_LBU:  load_data = {24'd0, byte_s};
            F3_LHU:  load_data = {16'd0, half_s};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load path: accept request, read aligned word, extract and
// extend the addressed lane, hold the result until the core takes it.
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_error
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        off_p0;
    logic [2:0]        f3_p0;
    logic [ADDR_W-1:0] mem_addr_p0;
    logic [31:0]       resp_data_p1;
    logic              resp_error_p1;
    logic [31:0]       load_data;
    logic              req_fire;
    logic              req_bad;

    assign req_fire = (state == ST_IDLE) && req_valid;
    assign req_bad  = !is_valid_f3(req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    load_extract u_extract (
        .mem_rdata (mem_rdata),
        .offset    (off_p0),
        .funct3    (f3_p0),
        .load_data (load_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = req_bad ? ST_RESP : ST_READ;
            ST_READ: state_nxt = ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: request latches; stage p1: response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            off_p0        <= '0;
            f3_p0         <= '0;
            mem_addr_p0   <= '0;
            resp_data_p1  <= '0;
            resp_error_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                off_p0        <= req_addr[1:0];
                f3_p0         <= req_funct3;
                resp_data_p1  <= '0;
                resp_error_p1 <= req_bad;
                if (!req_bad) mem_addr_p0 <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            if (state == ST_WAIT && mem_rvalid) resp_data_p1 <= load_data;
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign mem_rd_en  = (state == ST_READ);
    assign mem_addr   = mem_addr_p0;
    assign resp_valid = (state == ST_RESP);
    assign resp_data  = resp_data_p1;
    assign resp_error = resp_error_p1;

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit with a small reference model.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] WORD = 32'h80FF7F01;

    always #5 clk = ~clk;

    load_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_error (resp_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // One full transaction with cycle-exact checks. lat = memory latency,
    // bp = number of response cycles with resp_ready held low.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] word, input int lat, input int bp,
                            input logic [31:0] exp_d, input logic exp_e);
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        resp_ready = (bp == 0);
        tick;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_funct3 = 3'b011;
        chk({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
        if (exp_e) begin
            chk({tag, ".no_rd"}, {31'd0, mem_rd_en}, 32'd0);
        end else begin
            chk({tag, ".rd_en"}, {31'd0, mem_rd_en}, 32'd1);
            chk({tag, ".mem_addr"}, mem_addr, addr & ~32'd3);
            tick;
            chk({tag, ".rd_once"}, {31'd0, mem_rd_en}, 32'd0);
            for (int k = 1; k < lat; k++) tick;
            chk({tag, ".early_vld"}, {31'd0, resp_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = word;
            tick;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_A5A5;
        end
        chk({tag, ".vld"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, ".data"}, resp_data, exp_d);
        chk({tag, ".err"}, {31'd0, resp_error}, {31'd0, exp_e});
        for (int b = 1; b < bp; b++) begin
            tick;
            chk({tag, ".hold_vld"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, ".hold_data"}, resp_data, exp_d);
            chk({tag, ".hold_busy"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick;
        chk({tag, ".vld_drop"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] nxt_addr;
        logic [2:0]  nxt_f3;
        int          n;

        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; resp_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.vld", {31'd0, resp_valid}, 32'd0);
        chk("rst.data", resp_data, 32'd0);
        chk("rst.err", {31'd0, resp_error}, 32'd0);

        run_load("lb3",  32'h1000_0003, 3'b000, WORD, 1, 0, 32'hFFFF_FF80, 1'b0);
        run_load("lbu3", 32'h1000_0003, 3'b100, WORD, 1, 0, 32'h0000_0080, 1'b0);
        run_load("lb1",  32'h2000_0041, 3'b000, WORD, 1, 0, 32'h0000_007F, 1'b0);
        run_load("lbu2", 32'h0000_0006, 3'b100, WORD, 1, 0, 32'h0000_00FF, 1'b0);
        run_load("lh2",  32'h0000_0102, 3'b001, WORD, 1, 0, 32'hFFFF_80FF, 1'b0);
        run_load("lhu2", 32'h0000_0102, 3'b101, WORD, 1, 0, 32'h0000_80FF, 1'b0);
        run_load("lh0",  32'h0000_0100, 3'b001, WORD, 1, 0, 32'h0000_7F01, 1'b0);
        run_load("lw0",  32'h0000_0100, 3'b010, WORD, 1, 0, 32'h80FF_7F01, 1'b0);

        run_load("err_lw1", 32'h0000_0201, 3'b010, WORD, 1, 0, 32'd0, 1'b1);
        run_load("err_lh3", 32'h0000_0203, 3'b001, WORD, 1, 0, 32'd0, 1'b1);
        run_load("err_f3",  32'h0000_0200, 3'b011, WORD, 1, 0, 32'd0, 1'b1);

        // Stray read data while idle must not start or corrupt anything.
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick;
        mem_rvalid = 1'b0;
        chk("spur.vld", {31'd0, resp_valid}, 32'd0);
        run_load("lat5_bp4", 32'h0000_0302, 3'b001, WORD, 5, 4, 32'hFFFF_80FF, 1'b0);

        // Reset while a read is outstanding.
        req_valid = 1'b1; req_addr = 32'h0000_0400; req_funct3 = 3'b010;
        tick;
        req_valid = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw.rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rstw.mem_addr", mem_addr, 32'd0);
        chk("rstw.vld", {31'd0, resp_valid}, 32'd0);
        chk("rstw.data", resp_data, 32'd0);
        chk("rstw.err", {31'd0, resp_error}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_rvalid = 1'b0;
        tick;
        chk("rstw.late_vld", {31'd0, resp_valid}, 32'd0);
        chk("rstw.late_data", resp_data, 32'd0);
        run_load("rstw.lw", 32'h0000_0404, 3'b010, 32'h0BAD_F00D, 2, 0, 32'h0BAD_F00D, 1'b0);

        // Back-to-back requests with req_valid held high; request fields
        // are changed while busy and must be ignored.
        resp_ready = 1'b1;
        f3   = f3s[$urandom_range(0, 4)];
        off  = 2'($urandom_range(0, 3));
        if (f3 == 3'b010) off = 2'b00;
        else if (f3 == 3'b001 || f3 == 3'b101) off[0] = 1'b0;
        addr = ($urandom & ~32'd3) | {30'd0, off};
        req_valid = 1'b1; req_addr = addr; req_funct3 = f3;
        for (int i = 0; i < 5; i++) begin
            word = $urandom;
            n = 0;
            while (!req_ready && n < 20) begin tick; n++; end
            chk("b2b.ready", {31'd0, req_ready}, 32'd1);
            tick;
            nxt_f3  = f3s[$urandom_range(0, 4)];
            off     = 2'($urandom_range(0, 3));
            if (nxt_f3 == 3'b010) off = 2'b00;
            else if (nxt_f3 == 3'b001 || nxt_f3 == 3'b101) off[0] = 1'b0;
            nxt_addr   = ($urandom & ~32'd3) | {30'd0, off};
            req_addr   = nxt_addr;
            req_funct3 = nxt_f3;
            chk("b2b.busy", {31'd0, req_ready}, 32'd0);
            chk("b2b.mem_addr", mem_addr, addr & ~32'd3);
            n = 0;
            while (!mem_rd_en && n < 20) begin tick; n++; end
            tick;
            mem_rvalid = 1'b1; mem_rdata = word;
            tick;
            mem_rvalid = 1'b0;
            n = 0;
            while (!resp_valid && n < 20) begin tick; n++; end
            chk("b2b.vld", {31'd0, resp_valid}, 32'd1);
            chk("b2b.data", resp_data, ref_load(word, f3, addr[1:0]));
            chk("b2b.err", {31'd0, resp_error}, 32'd0);
            tick;
            addr = nxt_addr;
            f3   = nxt_f3;
        end
        req_valid = 1'b0;
        tick; tick; tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Sequential load path between the core's memory stage and the data memory port; the read-side counterpart of the store merge logic. Accepts one load request (byte address + funct3) per transaction, checks alignment, issues a word-aligned memory read, waits a variable number of cycles for read data, then extracts and sign/zero-extends the addressed byte, halfword or word. The result is held until the core accepts it.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_W  byte address.
- `req_funct3`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are invalid.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_addr`  out  ADDR_W  word address: `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_rdata`  in  32  read word; sampled only when `mem_rvalid` is high.
- `mem_rvalid`  in  1  read data valid, at least 1 cycle after `mem_rd_en`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  core accepts the result.
- `resp_data`  out  32  extended load result; 0 on error.
- `resp_error`  out  1  misaligned access or invalid funct3.

## Operation
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the address, funct3 and the 2-bit byte offset. If the request is invalid or misaligned, go to RESP with `resp_error`=1 and `resp_data`=0, and issue no memory access. Otherwise go to READ.
- Misaligned means LH/LHU with `offset[0]`=1, or LW with `offset`≠00. LB/LBU are never misaligned.
- READ: `mem_rd_en`=1 with `mem_addr` driven, for exactly one cycle, then go to WAIT.
- WAIT: hold until `mem_rvalid`. Capture the extracted result into the response register, then go to RESP.
- RESP: `resp_valid`=1, and data and error stay stable until `resp_ready`. When the handshake completes, go to IDLE.
- Extraction rules:
  - Byte: `rdata[8*off+7 : 8*off]`.
  - Halfword: `off[1]` selects bits 31:16, otherwise bits 15:0.
  - LB/LH sign-extend from the top bit. LBU/LHU zero-extend.
- `mem_rvalid` outside WAIT is ignored.
- `mem_addr` holds its last value outside READ. This is don't-care, but it must not be X after reset.

## Timing
- Reset values: state IDLE; `req_ready`=1; `mem_rd_en`=0; `mem_addr`=0; `resp_valid`=0; `resp_data`=0; `resp_error`=0.
- Valid load, with request accepted at edge 0:
  - `mem_rd_en` high in cycle 1.
  - Earliest `mem_rvalid` in cycle 2.
  - `resp_valid` high in cycle 3.
  - Minimum latency is 3 cycles, plus (N−1) for N cycles of memory latency.
- Error path: request accepted at edge 0, `resp_valid` high in cycle 1.
- Throughput: one request per transaction. `req_ready` is low from acceptance until the cycle after the RESP handshake. No back-to-back overlap.
- Response with `resp_ready` already high: `resp_valid` is high for exactly one cycle.
- Reset in any state, including WAIT with a read outstanding: the next cycle is IDLE with reset values. A `mem_rvalid` arriving after reset is ignored because the FSM is not in WAIT.
- `req_*` inputs are sampled only at acceptance. Changes afterwards have no effect.

## Structure
- Package `load_pkg`:
  - funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
  - FSM state encoding (2 bits).
  - A `is_misaligned(funct3, offset)` function.
- Sub-module `load_extract`: purely combinational. Inputs are `mem_rdata`, offset and funct3; output is the 32-bit extended value. It is instantiated once and registered into `resp_data` in WAIT.
- Top-level `load_unit` holds the FSM, the request latches and the handshake logic.

## Test plan
- Byte loads, mem word 0x80FF7F01, 1-cycle memory latency:
  - LB offset 3 -> 0xFFFFFF80.
  - LBU offset 3 -> 0x00000080.
  - LB offset 1 -> 0x0000007F.
  - `mem_addr` = address & ~3.
  - `resp_valid` exactly 3 cycles after acceptance.
- Halfword and word loads, same word:
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 2 -> 0x000080FF.
  - LH offset 0 -> 0x00007F01.
  - LW offset 0 -> 0x80FF7F01.
- Error requests:
  - LW offset 1, LH offset 3 and funct3=011 each give `resp_error`=1 and `resp_data`=0 in cycle 1.
  - `mem_rd_en` is never asserted.
- Variable latency and backpressure:
  - `mem_rvalid` delayed 5 cycles, with a spurious `mem_rvalid` pulsed during IDLE beforehand (ignored).
  - `resp_ready` held low for 4 cycles; `resp_data` is stable throughout.
  - `req_ready` stays low until the handshake completes.
- Reset mid-WAIT: assert `reset` for 1 cycle while waiting.
  - Outputs return to reset values.
  - A later `mem_rvalid` with 0xDEADBEEF produces no `resp_valid`.
  - A following LW returns correct data.
- Back-to-back requests: five random LB/LH/LW/LBU/LHU requests with `req_valid` held high.
  - Each is accepted only when `req_ready` is high.
  - Results match the reference model in order.
